// File: rtl/linear_layer_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : linear_layer_fifo_pkg
// Description : Shared types and constants for the Linear_Layer start-token
//               FIFO controller: FSM state encoding and err bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package linear_layer_fifo_pkg;

    // Occupancy state of a start-token FIFO
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fifo_state_t;

    // Bit positions inside the sticky err vector
    localparam int ERR_OVF = 0;
    localparam int ERR_UDF = 1;

endpackage : linear_layer_fifo_pkg
`default_nettype wire

// File: rtl/start_fifo_srl.sv
`default_nettype none
// ============================================================================
// Module      : start_fifo_srl
// Description : Shift-register token storage. A write shifts every slot up by
//               one and places the new token in slot 0; the read port is an
//               asynchronous mux selected by addr. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module start_fifo_srl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    // Index width needed to address exactly DEPTH slots
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0]      idx;

    assign idx = addr[IDX_W-1:0];

    // Shift the whole chain on a write; newest token lands in slot 0
    always_ff @(posedge clk) begin
        if (we) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[idx];

endmodule : start_fifo_srl
`default_nettype wire

// File: rtl/linear_layer_start_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : linear_layer_start_fifo_ctrl
// Description : ap_fifo-style control for a start-token FIFO. Tracks
//               occupancy with a three-state FSM, drives registered
//               full_n/empty_n/almost_full_n, and addresses the shift-register
//               storage so the head token is shown ahead.
//               Optional macro START_FIFO_ERR_CHECK_EN enables sticky
//               overflow/underflow flags on err; otherwise err is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module linear_layer_start_fifo_ctrl
    import linear_layer_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2,
    parameter int AF_MARGIN  = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    output logic                  if_almost_full_n,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   count,
    output logic [1:0]            err
);

    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] CNT_LAST  = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam int                  AF_THRESH = DEPTH - AF_MARGIN;
    // With a margin covering the whole FIFO the flag is low even when empty
    localparam logic                AF_RST    = (AF_MARGIN >= DEPTH) ? 1'b0 : 1'b1;

    fifo_state_t           state;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH:0]   count_next;
    logic [ADDR_WIDTH:0]   count_m1;
    logic [ADDR_WIDTH-1:0] srl_addr;

    // Handshakes use only registered flags, so full_n/empty_n never loop back
    assign push = if_write & if_full_n;
    assign pop  = if_read  & if_empty_n;

    // Occupancy update: simultaneous push and pop cancel out
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_ONE;
        end else if (pop && !push) begin
            count_next = count - CNT_ONE;
        end
    end

    // Head lives at slot count-1; a shift during push&pop keeps it there
    assign count_m1 = count - CNT_ONE;
    assign srl_addr = (count == '0) ? '0 : count_m1[ADDR_WIDTH-1:0];

    // Occupancy FSM with registered handshake flags
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state            <= EMPTY;
            count            <= '0;
            if_empty_n       <= 1'b0;
            if_full_n        <= 1'b1;
            if_almost_full_n <= AF_RST;
        end else begin
            count            <= count_next;
            if_almost_full_n <= (int'(count_next) < AF_THRESH);
            case (state)
                EMPTY: begin
                    if (push) begin
                        state      <= PARTIAL;
                        if_empty_n <= 1'b1;
                    end
                end
                PARTIAL: begin
                    if (push && !pop && (count == CNT_LAST)) begin
                        state     <= FULL;
                        if_full_n <= 1'b0;
                    end else if (pop && !push && (count == CNT_ONE)) begin
                        state      <= EMPTY;
                        if_empty_n <= 1'b0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state     <= PARTIAL;
                        if_full_n <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    if_empty_n <= 1'b0;
                    if_full_n  <= 1'b1;
                end
            endcase
        end
    end

`ifdef START_FIFO_ERR_CHECK_EN
    logic [1:0] err_flags;

    // Sticky protocol-misuse flags: write while full, read while empty
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            err_flags <= 2'b00;
        end else begin
            if (if_write && !if_full_n) begin
                err_flags[ERR_OVF] <= 1'b1;
            end
            if (if_read && !if_empty_n) begin
                err_flags[ERR_UDF] <= 1'b1;
            end
        end
    end

    assign err = err_flags;
`else
    assign err = 2'b00;
`endif

    start_fifo_srl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_srl (
        .clk  (ap_clk),
        .we   (push),
        .addr (srl_addr),
        .din  (if_din),
        .dout (if_dout)
    );

endmodule : linear_layer_start_fifo_ctrl
`default_nettype wire

// File: tb/tb_linear_layer_start_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_linear_layer_start_fifo_ctrl
// Description : Scoreboard bench for the start-token FIFO controller. A
//               DEPTH=2 instance covers fill, full-with-pop, streaming, drain,
//               misuse flags and async reset; a DEPTH=4/AF_MARGIN=1 instance
//               covers almost-full. Expected tokens and status snapshots are
//               queued by the driver and consumed by a negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_linear_layer_start_fifo_ctrl;

`ifdef START_FIFO_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;

    // DEPTH=2 instance
    logic       wr, rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full_n, afull_n, empty_n;
    logic [1:0] cnt;
    logic [1:0] err;

    // DEPTH=4 instance
    logic       wr4, rd4;
    logic [7:0] din4;
    logic [7:0] dout4;
    logic       full_n4, afull_n4, empty_n4;
    logic [2:0] cnt4;
    logic [1:0] err4;

    typedef struct {
        string      name;
        int         unit;
        int         cnt;
        logic       en;
        logic       fn;
        logic       afn;
        logic [1:0] er;
        bit         chk_dout;
        logic [7:0] dout;
    } chk_t;

    chk_t       chk_q[$];
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         passes = 0;

    linear_layer_start_fifo_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(2), .AF_MARGIN(0)
    ) dut (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .if_write(wr), .if_din(din), .if_full_n(full_n),
        .if_almost_full_n(afull_n), .if_read(rd), .if_dout(dout),
        .if_empty_n(empty_n), .count(cnt), .err(err)
    );

    linear_layer_start_fifo_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4), .AF_MARGIN(1)
    ) dut4 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .if_write(wr4), .if_din(din4), .if_full_n(full_n4),
        .if_almost_full_n(afull_n4), .if_read(rd4), .if_dout(dout4),
        .if_empty_n(empty_n4), .count(cnt4), .err(err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic exp_st(input string name, input int unit, input int c,
                          input logic en, input logic fn, input logic afn,
                          input logic [1:0] er, input bit cd, input logic [7:0] d);
        chk_t s;
        s.name = name; s.unit = unit; s.cnt = c; s.en = en; s.fn = fn;
        s.afn = afn; s.er = er; s.chk_dout = cd; s.dout = d;
        chk_q.push_back(s);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: check every accepted read against the token queue, then any
    // status snapshots queued since the last falling edge
    always @(negedge clk) begin
        if (rd && empty_n) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL pop_data: got %0h expected no token", dout);
            end else begin
                cmp("pop_data", {24'd0, dout}, {24'd0, exp_q.pop_front()});
            end
        end
        while (chk_q.size() > 0) begin
            chk_t s;
            s = chk_q.pop_front();
            if (s.unit == 0) begin
                cmp({s.name, ".count"},   {30'd0, cnt},     32'(s.cnt));
                cmp({s.name, ".empty_n"}, {31'd0, empty_n}, {31'd0, s.en});
                cmp({s.name, ".full_n"},  {31'd0, full_n},  {31'd0, s.fn});
                cmp({s.name, ".afull_n"}, {31'd0, afull_n}, {31'd0, s.afn});
                cmp({s.name, ".err"},     {30'd0, err},     {30'd0, s.er});
                if (s.chk_dout) cmp({s.name, ".dout"}, {24'd0, dout}, {24'd0, s.dout});
            end else begin
                cmp({s.name, ".count"},   {29'd0, cnt4},     32'(s.cnt));
                cmp({s.name, ".empty_n"}, {31'd0, empty_n4}, {31'd0, s.en});
                cmp({s.name, ".full_n"},  {31'd0, full_n4},  {31'd0, s.fn});
                cmp({s.name, ".afull_n"}, {31'd0, afull_n4}, {31'd0, s.afn});
                cmp({s.name, ".err"},     {30'd0, err4},     {30'd0, s.er});
                if (s.chk_dout) cmp({s.name, ".dout"}, {24'd0, dout4}, {24'd0, s.dout});
            end
        end
    end

    initial begin
        logic [7:0] cseq [4];
        cseq[0] = 8'hC0; cseq[1] = 8'hC1; cseq[2] = 8'hC2; cseq[3] = 8'hC3;

        rst_n = 1'b0;
        wr = 1'b0; rd = 1'b0; din = 8'h00;
        wr4 = 1'b0; rd4 = 1'b0; din4 = 8'h00;
        exp_st("reset", 0, 0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00);
        exp_st("reset4", 4, 0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00);

        // Release reset and write on the very first active edge
        @(negedge clk); #1;
        rst_n = 1'b1;
        wr = 1'b1; din = 8'hA0; exp_q.push_back(8'hA0);
        cyc();
        din = 8'hB0; exp_q.push_back(8'hB0);
        cyc();
        wr = 1'b0;
        exp_st("fill", 0, 2, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 8'hA0);

        // Full: write refused while the pop proceeds (EE must not enter)
        wr = 1'b1; rd = 1'b1; din = 8'hEE;
        cyc();
        wr = 1'b0; rd = 1'b0;
        exp_st("full_rw", 0, 1, 1'b1, 1'b1, 1'b1, ERR_EN ? 2'b01 : 2'b00, 1'b1, 8'hB0);

        // Streaming push&pop at count=1, no bubbles
        for (int i = 0; i < 4; i++) begin
            wr = 1'b1; rd = 1'b1; din = cseq[i]; exp_q.push_back(cseq[i]);
            cyc();
        end
        wr = 1'b0; rd = 1'b0;
        exp_st("stream", 0, 1, 1'b1, 1'b1, 1'b1, ERR_EN ? 2'b01 : 2'b00, 1'b1, 8'hC3);

        // Drain to empty
        rd = 1'b1;
        cyc();
        rd = 1'b0;
        exp_st("drain", 0, 0, 1'b0, 1'b1, 1'b1, ERR_EN ? 2'b01 : 2'b00, 1'b0, 8'h00);

        // Read while empty: refused, underflow flag is sticky
        rd = 1'b1;
        cyc();
        rd = 1'b0;
        exp_st("underflow", 0, 0, 1'b0, 1'b1, 1'b1, ERR_EN ? 2'b11 : 2'b00, 1'b0, 8'h00);
        cyc();
        exp_st("udf_sticky", 0, 0, 1'b0, 1'b1, 1'b1, ERR_EN ? 2'b11 : 2'b00, 1'b0, 8'h00);

        // Refill, then write into a full FIFO and drain both tokens in order
        wr = 1'b1; din = 8'h11; exp_q.push_back(8'h11);
        cyc();
        din = 8'h22; exp_q.push_back(8'h22);
        cyc();
        din = 8'h33;
        cyc();
        wr = 1'b0;
        exp_st("overflow", 0, 2, 1'b1, 1'b0, 1'b0, ERR_EN ? 2'b11 : 2'b00, 1'b1, 8'h11);
        rd = 1'b1;
        cyc();
        cyc();
        rd = 1'b0;
        exp_st("drain2", 0, 0, 1'b0, 1'b1, 1'b1, ERR_EN ? 2'b11 : 2'b00, 1'b0, 8'h00);

        // Almost-full on the DEPTH=4, AF_MARGIN=1 instance
        wr4 = 1'b1; din4 = 8'h41;
        cyc();
        din4 = 8'h42;
        cyc();
        wr4 = 1'b0;
        exp_st("af_two", 4, 2, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 8'h41);
        wr4 = 1'b1; din4 = 8'h43;
        cyc();
        wr4 = 1'b0;
        exp_st("af_three", 4, 3, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 8'h41);

        // Mid-stream asynchronous reset at count=2
        wr = 1'b1; din = 8'h55; exp_q.push_back(8'h55);
        cyc();
        din = 8'h66; exp_q.push_back(8'h66);
        cyc();
        wr = 1'b0;
        exp_st("pre_rst", 0, 2, 1'b1, 1'b0, 1'b0, ERR_EN ? 2'b11 : 2'b00, 1'b1, 8'h55);
        @(negedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        exp_st("async_rst", 0, 0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00);
        exp_st("async_rst4", 4, 0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00);
        @(negedge clk); #1;
        rst_n = 1'b1;
        cyc();
        @(negedge clk); #1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_linear_layer_start_fifo_ctrl
`default_nettype wire

// File: doc/linear_layer_start_fifo_ctrl.md
# linear_layer_start_fifo_ctrl

Control unit for the start-token FIFOs between Linear_Layer_i4xi4_q dataflow processes (e.g. the start path into PE_i4xi4_pack_2x2). It owns the shift-register storage sub-module and produces its write enable and read address. It tracks occupancy, exposes the HLS-style ap_fifo handshake (full_n/empty_n) to producer and consumer, and flags protocol misuse. Read data is show-ahead with one-cycle write-to-visible latency.

## Interface
- DATA_WIDTH, 1: token width in bits.
- ADDR_WIDTH, 1: storage address width; DEPTH ≤ 2^ADDR_WIDTH.
- DEPTH, 2: number of token slots, ≥ 2.
- AF_MARGIN, 0: almost-full threshold; almost_full_n deasserts when count ≥ DEPTH − AF_MARGIN.

Ports:
- ap_clk  in  1  clock; all state updates on rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- if_write  in  1  producer write request.
- if_din  in  DATA_WIDTH  producer data.
- if_full_n  out  1  high = slot free; a write is accepted when if_write & if_full_n.
- if_almost_full_n  out  1  high = count < DEPTH − AF_MARGIN.
- if_read  in  1  consumer read request.
- if_dout  out  DATA_WIDTH  head token; valid only while if_empty_n.
- if_empty_n  out  1  high = token available; a read is accepted when if_read & if_empty_n.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- err  out  2  sticky {underflow, overflow}; see Configuration.

## Operation
- push = if_write & if_full_n; pop = if_read & if_empty_n.
- The FSM has three states: EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH). Its outputs are:
  - if_empty_n = (state≠EMPTY), registered.
  - if_full_n = (state≠FULL), registered.
- count transitions:
  - push only: count+1.
  - pop only: count−1.
  - push & pop: count unchanged.
  - neither: hold.
- FSM transitions:
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on push-only when count=DEPTH−1.
  - PARTIAL→EMPTY on pop-only when count=1.
  - FULL→PARTIAL on pop.
- Storage:
  - srl_we = push; the storage shifts, and the new token enters slot 0.
  - srl_addr = count−1, clamped to 0 when count=0.
  - if_dout = storage[srl_addr], combinational.
- Simultaneous push & pop in PARTIAL: the head is read at the current srl_addr before the shift, and the address stays unchanged. FIFO order is preserved.
- In FULL, a write is refused (if_full_n=0) while a pop proceeds, so count drops to DEPTH−1. In EMPTY, a read is refused while a push proceeds.
- Reset values:
  - count=0, state EMPTY.
  - if_empty_n=0, if_full_n=1, if_almost_full_n=1 (0 if AF_MARGIN ≥ DEPTH), err=0.
  - Storage contents are not cleared.
- Reset asserted mid-operation clears all control state immediately; stored tokens are lost.

## Timing
- Write accepted at edge k: if_empty_n=1 and if_dout=token from cycle k+1.
- Read accepted at edge k: the next head (or empty_n=0) is visible from cycle k+1.
- Throughput is one push and one pop per cycle with no bubbles.
- if_full_n and if_empty_n never depend combinationally on if_write or if_read.
- Reset release: the first write can be accepted on the first edge with ap_rst_n=1.

## Configuration
- START_FIFO_ERR_CHECK_EN defined:
  - err[0] sets on if_write & ~if_full_n.
  - err[1] sets on if_read & ~if_empty_n.
  - Both flags are sticky until reset.
- Undefined: err is tied to 0 and no checking logic is generated.

## Structure
- The shared package linear_layer_fifo_pkg holds:
  - the FSM state enum fifo_state_t {EMPTY, PARTIAL, FULL};
  - the err bit index constants ERR_OVF=0 and ERR_UDF=1.
- One sub-module, start_fifo_srl: ports clk, we, addr, din, dout; shift-register storage; no reset.

## Test plan
- Reset, then DEPTH=2, write A then B on consecutive cycles, no reads → count=2, if_full_n=0 after the second edge, if_dout=A.
- Full FIFO, if_write=1 and if_read=1 in the same cycle → only the pop is taken; count=1, if_dout=B, B is not overwritten.
- count=1, push C and pop together for 4 cycles with a streaming sequence → count stays 1, if_dout follows the inputs with one-cycle lag, no bubbles.
- Empty FIFO, if_read=1 with the macro defined → err=2'b10 sticky; count stays 0. Without the macro → err=0.
- DEPTH=4, AF_MARGIN=1, three writes → if_almost_full_n=0 with if_full_n=1.
- Drop ap_rst_n mid-stream at count=2 → asynchronously count=0, if_empty_n=0, if_full_n=1 before the next edge.
